// File: rtl/gshare_bpred.sv
`default_nettype none
// ============================================================================
// Module   : gshare_bpred
// Brief    : Bimodal/gshare direction predictor with tagged BTB, speculative
//            GHR with mispredict recovery and a reset-time init sweep.
//            Optional lookup/mispredict statistics under BPRED_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module gshare_bpred #(
  parameter int ENTRIES = 1024,
  parameter int CTR_W   = 2,
  parameter int HIST_W  = 10,
  parameter int TAG_W   = 8,
  parameter int ADDR_W  = 32,
  parameter int MODE    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  input  logic              lookup_en_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  output logic              btb_hit_o,
  output logic [HIST_W-1:0] pred_hist_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [HIST_W-1:0] upd_hist_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  output logic              ready_o
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]       stat_lookups_o,
  output logic [31:0]       stat_mispred_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [CTR_W-1:0] C_CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] C_CTR_MAX  = '1;
  localparam logic [IDX_W-1:0] C_PTR_LAST = IDX_W'(ENTRIES - 1);

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [HIST_W-1:0] r_ghr;
  logic [CTR_W-1:0]  r_ctr     [ENTRIES];
  logic [ENTRIES-1:0] r_btb_v;
  logic [TAG_W-1:0]  r_btb_tag [ENTRIES];
  logic [ADDR_W-1:0] r_btb_tgt [ENTRIES];

  function automatic logic [IDX_W-1:0] f_cidx(input logic [ADDR_W-1:0] pc,
                                              input logic [HIST_W-1:0] h);
    if (MODE == 1) f_cidx = pc[IDX_W+1:2] ^ IDX_W'(h);
    else           f_cidx = pc[IDX_W+1:2];
  endfunction

  logic              w_run;
  logic [IDX_W-1:0]  w_lk_pidx;
  logic [IDX_W-1:0]  w_lk_cidx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_hit;
  logic [IDX_W-1:0]  w_up_pidx;
  logic [IDX_W-1:0]  w_up_cidx;
  logic [TAG_W-1:0]  w_up_tag;
  logic              w_upd_en;
  logic [CTR_W-1:0]  w_ctr_old;
  logic [CTR_W-1:0]  w_ctr_new;
  logic [HIST_W-1:0] w_ghr_spec;
  logic [HIST_W-1:0] w_ghr_rec;
  logic              w_unused_ok;

  assign w_run     = (r_state == S_RUN);
  assign w_lk_pidx = lookup_pc_i[IDX_W+1:2];
  assign w_lk_tag  = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_lk_cidx = f_cidx(lookup_pc_i, r_ghr);
  assign w_up_pidx = upd_pc_i[IDX_W+1:2];
  assign w_up_tag  = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_up_cidx = f_cidx(upd_pc_i, upd_hist_i);
  assign w_unused_ok = ^{lookup_pc_i, upd_pc_i};

  // Lookup is forced quiet until the sweep has finished.
  assign w_hit = w_run && r_btb_v[w_lk_pidx] && (r_btb_tag[w_lk_pidx] == w_lk_tag);

  assign btb_hit_o     = w_hit;
  assign pred_taken_o  = w_hit & r_ctr[w_lk_cidx][CTR_W-1];
  assign pred_target_o = w_hit ? r_btb_tgt[w_lk_pidx] : '0;
  assign pred_hist_o   = w_run ? r_ghr : '0;
  assign ready_o       = w_run;

  assign w_upd_en  = w_run && reset && upd_valid_i;
  assign w_ctr_old = r_ctr[w_up_cidx];
  assign w_ctr_new = upd_taken_i ? ((w_ctr_old == C_CTR_MAX) ? w_ctr_old : w_ctr_old + 1'b1)
                                 : ((w_ctr_old == '0)        ? w_ctr_old : w_ctr_old - 1'b1);

  generate
    if (HIST_W == 1) begin : g_hist1
      assign w_ghr_spec = pred_taken_o;
      assign w_ghr_rec  = upd_taken_i;
    end else begin : g_histn
      assign w_ghr_spec = {r_ghr[HIST_W-2:0], pred_taken_o};
      assign w_ghr_rec  = {upd_hist_i[HIST_W-2:0], upd_taken_i};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_ghr   <= '0;
    end else if (!w_run) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == C_PTR_LAST) r_state <= S_RUN;
    end else begin
      // Recovery takes priority over the speculative shift.
      if (upd_valid_i && upd_mispred_i)   r_ghr <= w_ghr_rec;
      else if (lookup_en_i && w_hit)      r_ghr <= w_ghr_spec;
    end
  end

  // Tables have no reset; the sweep initialises them one entry per cycle.
  always_ff @(posedge clk) begin
    if (reset && !w_run) begin
      r_ctr[r_ptr]   <= C_CTR_INIT;
      r_btb_v[r_ptr] <= 1'b0;
    end else if (w_upd_en) begin
      r_ctr[w_up_cidx] <= w_ctr_new;
      if (upd_taken_i) begin
        r_btb_v[w_up_pidx]   <= 1'b1;
        r_btb_tag[w_up_pidx] <= w_up_tag;
        r_btb_tgt[w_up_pidx] <= upd_target_i;
      end
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] r_stat_lk;
  logic [31:0] r_stat_mp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_lk <= '0;
      r_stat_mp <= '0;
    end else if (w_run) begin
      if (lookup_en_i && w_hit)         r_stat_lk <= r_stat_lk + 32'd1;
      if (upd_valid_i && upd_mispred_i) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_lookups_o = r_stat_lk;
  assign stat_mispred_o = r_stat_mp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gshare_bpred.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_bpred
// Brief    : Directed bench for gshare_bpred; a bimodal and a gshare instance
//            share stimulus. Statistics checked when BPRED_STATS_EN is set.
// Revision : 1.0  initial release
// ============================================================================
module tb_gshare_bpred;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        lookup_en;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_hist;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;

  logic        a_taken, a_hit, a_ready;
  logic [31:0] a_target;
  logic [3:0]  a_hist;
  logic        b_taken, b_hit, b_ready;
  logic [31:0] b_target;
  logic [3:0]  b_hist;
`ifdef BPRED_STATS_EN
  logic [31:0] a_slk, a_smp, b_slk, b_smp;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gshare_bpred #(.ENTRIES(16), .CTR_W(2), .HIST_W(4), .TAG_W(8), .ADDR_W(32), .MODE(0)) u_bim (
    .clk(clk), .reset(reset),
    .lookup_pc_i(lookup_pc), .lookup_en_i(lookup_en),
    .pred_taken_o(a_taken), .pred_target_o(a_target), .btb_hit_o(a_hit), .pred_hist_o(a_hist),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_hist_i(upd_hist), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispred_i(upd_mispred), .ready_o(a_ready)
`ifdef BPRED_STATS_EN
    , .stat_lookups_o(a_slk), .stat_mispred_o(a_smp)
`endif
  );

  gshare_bpred #(.ENTRIES(16), .CTR_W(2), .HIST_W(4), .TAG_W(8), .ADDR_W(32), .MODE(1)) u_gsh (
    .clk(clk), .reset(reset),
    .lookup_pc_i(lookup_pc), .lookup_en_i(lookup_en),
    .pred_taken_o(b_taken), .pred_target_o(b_target), .btb_hit_o(b_hit), .pred_hist_o(b_hist),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_hist_i(upd_hist), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispred_i(upd_mispred), .ready_o(b_ready)
`ifdef BPRED_STATS_EN
    , .stat_lookups_o(b_slk), .stat_mispred_o(b_smp)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic [3:0] h, input logic mp);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_hist = h; upd_mispred = mp;
    cyc();
    upd_valid = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic en);
    lookup_pc = pc; lookup_en = en;
    #1;
  endtask

  initial begin
    reset = 1'b0; lookup_pc = '0; lookup_en = 1'b0; upd_valid = 1'b0; upd_pc = '0;
    upd_hist = '0; upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
    repeat (3) cyc();
    chk("rst ready a", a_ready, 0);
    chk("rst ready b", b_ready, 0);
    chk("rst hist b", b_hist, 0);

    // Sweep: 16 cycles not ready, with an update issued throughout that must be ignored.
    reset = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1; upd_target = 32'h200;
    lookup_pc = 32'h44;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init ready a", a_ready, 0);
      chk("init taken a", a_taken, 0);
      chk("init hit b", b_hit, 0);
      cyc();
    end
    upd_valid = 1'b0;
    #1;
    chk("run ready a", a_ready, 1);
    chk("run ready b", b_ready, 1);
    chk("init upd dropped hit a", a_hit, 0);
    chk("init upd dropped hit b", b_hit, 0);

    // Counter training at 0x40.
    upd(32'h40, 1, 32'h100, 4'h0, 0);
    upd(32'h40, 1, 32'h100, 4'h0, 0);
    look(32'h40, 0);
    chk("train hit a", a_hit, 1);
    chk("train taken a", a_taken, 1);
    chk("train target a", a_target, 32'h100);
    chk("train taken b", b_taken, 1);
    chk("train target b", b_target, 32'h100);
    repeat (3) upd(32'h40, 0, 32'h0, 4'h0, 0);
    #1;
    chk("nt taken a", a_taken, 0);
    chk("nt hit a", a_hit, 1);
    chk("nt taken b", b_taken, 0);
    upd(32'h40, 0, 32'h0, 4'h0, 0);
    upd(32'h40, 1, 32'h100, 4'h0, 0);
    #1;
    chk("sat0 then +1 a", a_taken, 0);
    upd(32'h40, 1, 32'h100, 4'h0, 0);
    #1;
    chk("sat0 then +2 a", a_taken, 1);
    chk("sat0 then +2 b", b_taken, 1);
    upd(32'h40, 1, 32'h100, 4'h0, 0);
    upd(32'h40, 1, 32'h100, 4'h0, 0);
    upd(32'h40, 0, 32'h0, 4'h0, 0);
    #1;
    chk("sat3 then -1 a", a_taken, 1);
    chk("sat3 then -1 b", b_taken, 1);
    upd(32'h40, 0, 32'h0, 4'h0, 0);
    #1;
    chk("sat3 then -2 a", a_taken, 0);

    // Aliasing: same pidx, different tag.
    upd(32'h40, 1, 32'h100, 4'h0, 0);
    look(32'h80, 0);
    chk("alias hit a", a_hit, 0);
    chk("alias taken a", a_taken, 0);
    chk("alias target a", a_target, 0);
    chk("alias hit b", b_hit, 0);
    look(32'h40, 0);
    chk("alias owner taken a", a_taken, 1);

    // Same-cycle read/write at index 5.
    upd(32'h14, 1, 32'h300, 4'h0, 0);
    upd(32'h14, 0, 32'h0, 4'h0, 0);
    lookup_pc = 32'h14;
    upd_valid = 1'b1; upd_pc = 32'h14; upd_taken = 1'b1; upd_target = 32'h300; upd_hist = 4'h0;
    #1;
    chk("rbw hit a", a_hit, 1);
    chk("rbw old taken a", a_taken, 0);
    chk("rbw old taken b", b_taken, 0);
    cyc();
    upd_valid = 1'b0;
    #1;
    chk("rbw new taken a", a_taken, 1);
    chk("rbw new taken b", b_taken, 1);
    chk("hist idle b", b_hist, 0);

    // Speculative GHR: prime gshare counters at 0^1=1 and 0^3=3.
    upd(32'h40, 1, 32'h100, 4'h1, 0);
    upd(32'h40, 1, 32'h100, 4'h3, 0);
    look(32'h40, 1);
    chk("spec1 hist b", b_hist, 4'h0);
    chk("spec1 taken b", b_taken, 1);
    cyc();
    chk("spec2 hist b", b_hist, 4'h1);
    chk("spec2 taken b", b_taken, 1);
    cyc();
    chk("spec3 hist b", b_hist, 4'h3);
    chk("spec3 taken b", b_taken, 1);
    cyc();
    chk("spec hist a", a_hist, 4'h7);
    chk("spec hist b", b_hist, 4'h7);
    // gshare index 7 is untrained, bimodal index 0 is saturated.
    chk("gsh idx7 taken b", b_taken, 0);
    chk("bim idx0 taken a", a_taken, 1);
    upd(32'h40, 0, 32'h0, 4'b0010, 1);
    lookup_en = 1'b0;
    #1;
    chk("recover hist a", a_hist, 4'b0100);
    chk("recover hist b", b_hist, 4'b0100);
    look(32'h80, 1);
    cyc();
    chk("miss no shift b", b_hist, 4'b0100);
    look(32'h40, 1);
    upd(32'h80, 0, 32'h0, 4'h0, 1);
    lookup_en = 1'b0;
    #1;
    chk("recover2 hist b", b_hist, 4'h0);
`ifdef BPRED_STATS_EN
    chk("stat lookups a", a_slk, 5);
    chk("stat mispred a", a_smp, 2);
    chk("stat lookups b", b_slk, 5);
    chk("stat mispred b", b_smp, 2);
`endif

    // Reset mid-RUN with an in-flight update that must be dropped.
    reset = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h600;
    cyc();
    upd_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid rst ready a", a_ready, 0);
    chk("mid rst hist b", b_hist, 0);
`ifdef BPRED_STATS_EN
    chk("mid rst stat lk b", b_slk, 0);
    chk("mid rst stat mp b", b_smp, 0);
`endif
    for (int i = 0; i < 16; i++) begin
      chk("resweep ready b", b_ready, 0);
      cyc();
    end
    chk("resweep done a", a_ready, 1);
    chk("resweep done b", b_ready, 1);
`ifdef BPRED_STATS_EN
    chk("stat hold lk a", a_slk, 0);
    chk("stat hold mp a", a_smp, 0);
`endif
    for (int i = 0; i < 16; i++) begin
      look(32'h40 + 32'(i * 4), 0);
      chk("post sweep hit a", a_hit, 0);
      chk("post sweep hit b", b_hit, 0);
    end
    look(32'h14, 0);
    chk("post sweep idx5 hit a", a_hit, 0);
    look(32'h80, 0);
    chk("dropped upd hit a", a_hit, 0);
    chk("dropped upd target b", b_target, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
